mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one multi-cycle, pipelined main memory between the I-cache and D-cache miss handlers.
//  Grants one requester at a time and sequences the transaction:
//   - block fill: WORDS_PER_BLOCK word reads, issued on consecutive cycles;
//   - single-word write: D side only (write-through).
//  Returned words are steered to the granted side with a word index.
//  Sits between the cache controllers and the main memory model; the pipeline stalls on the caches' miss signals.
// PARAMETERS
//  ADDR_W           16  byte-address width
//  DATA_W           16  word width
//  WORDS_PER_BLOCK  8   words per cache block (power of 2); byte offset bits OFF = log2(WPB)+1
//  MEM_LAT          4   cycles from mem_en (read) to mem_rvalid for that word
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  i_req         in   1       I-cache miss: fill request (level)
//  i_addr        in   ADDR_W  I fill address; low OFF bits ignored
//  i_gnt         out  1       I owns memory, grant through i_done
//  i_data_valid  out  1       fill_data is a word for I
//  i_word_idx    out  log2WPB index of that word in the block
//  i_done        out  1       1-cycle pulse: I transaction complete
//  d_req         in   1       D-cache request (level)
//  d_wr          in   1       1 = single-word write, 0 = block fill
//  d_addr        in   ADDR_W  D address (word-aligned for writes)
//  d_wdata       in   DATA_W  D write data
//  d_gnt, d_data_valid, d_word_idx, d_done   out   as I side
//  fill_data     out  DATA_W  = mem_rdata, shared by both sides
//  mem_en        out  1       memory access strobe
//  mem_wr        out  1       1 = write
//  mem_addr      out  ADDR_W  memory byte address
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  memory read data
//  mem_rvalid    in   1       mem_rdata valid
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): IDLE; every output except fill_data = 0; issue/return counters = 0; last_gnt = I.
//   fill_data follows mem_rdata at all times.
//  FSM: IDLE, FILL_I, FILL_D, WRITE_D. Registered grant.
//  IDLE:
//   - Reqs sampled at edge T; gnt high from cycle T+1.
//   - Only one req: that side wins. Both reqs: the side != last_gnt wins; last_gnt updates at every grant.
//   - Winner D with d_wr=1 -> WRITE_D. Winner D with d_wr=0 -> FILL_D. Winner I -> FILL_I.
//   - Address/wdata/d_wr are captured at grant; requester inputs are not used afterwards.
//  FILL_x:
//   - Issue: cycles T+1..T+WPB, mem_en=1, mem_wr=0, mem_addr={addr[ADDR_W-1:OFF], issue_cnt, 1'b0}, issue_cnt 0..WPB-1.
//   - Return: each mem_rvalid -> x_data_valid=1 (combinational), x_word_idx=ret_cnt, ret_cnt++.
//   - x_done pulses with the last x_data_valid (ret_cnt=WPB-1); next state IDLE. Fill occupies WPB+MEM_LAT cycles.
//  WRITE_D: single cycle T+1:
//   - mem_en=mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
//   - d_done=1 and d_gnt=1 in the same cycle; IDLE at T+2.
//  Counters are log2(WPB) bits wide, wrap to 0 after the transaction, and are cleared on entering IDLE.
//  Req level in IDLE is a new request; requester must drop req the cycle after done to avoid re-fill.
//  Req dropped mid-transaction: ignored; the transaction completes.
//  mem_rvalid in IDLE or WRITE_D (e.g. stale after reset): ignored, no data_valid.
//  Never both gnts high. Never data_valid to the non-granted side. mem_en low in IDLE.
//  Reset mid-transaction: immediate abort as in reset; the next request restarts from word 0.
// TESTING
//  1 i_req, i_addr=0x1234 at cycle 0 -> i_gnt cycles 1-12; mem_addr 0x1230,0x1232..0x123E cycles 1-8;
//    i_data_valid cycles 5-12, idx 0-7; i_done cycle 12 only.
//  2 i_req and d_req (d_wr=0) together after reset -> D granted first; I granted at d_done+2;
//    both again -> D (alternation).
//  3 d_req, d_wr=1, d_addr=0x0100, d_wdata=0xBEEF -> cycle 1: mem_en=mem_wr=1, addr 0x0100, wdata 0xBEEF,
//    d_done=1; no data_valid; busy low cycle 2.
//  4 rst low at cycle 6 of an I fill -> all outputs 0 at once; mem_rvalid pulses ignored;
//    new i_req fetches idx 0..7 fresh.
//  5 i_req held high across two fills -> second i_gnt rises 2 cycles after first i_done; no overlap.
//  6 d_req dropped at cycle 3 of a D fill -> all 8 words delivered, d_done pulses; no new grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache and D-cache miss handlers.
// One requester owns memory at a time. A block fill issues WORDS_PER_BLOCK reads on
// consecutive cycles and steers the returned words, tagged with their index, to the
// owning side. The D side may also issue a single-word write-through.
//
// Ports
//   clk, rst                          clock (rising edge), asynchronous active-low reset
//   i_req, i_addr                     I-cache fill request and block address
//   i_gnt, i_data_valid, i_word_idx   I ownership, returned-word strobe and its block index
//   i_done                            1-cycle pulse on the last I word
//   d_req, d_wr, d_addr, d_wdata      D-cache request: fill (d_wr=0) or single-word write
//   d_gnt, d_data_valid, d_word_idx, d_done   as for the I side
//   fill_data                         memory read data, shared by both sides
//   mem_en, mem_wr, mem_addr, mem_wdata, mem_rdata, mem_rvalid   main memory interface
//   busy                              a transaction is in progress
module mem_arbiter #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LAT         = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_req,
  input  logic [ADDR_W-1:0]                  i_addr,
  output logic                               i_gnt,
  output logic                               i_data_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] i_word_idx,
  output logic                               i_done,
  input  logic                               d_req,
  input  logic                               d_wr,
  input  logic [ADDR_W-1:0]                  d_addr,
  input  logic [DATA_W-1:0]                  d_wdata,
  output logic                               d_gnt,
  output logic                               d_data_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] d_word_idx,
  output logic                               d_done,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_rvalid,
  output logic                               busy
);

  localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned Off  = IdxW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {StIdle, StFillI, StFillD, StWriteD} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [IdxW-1:0]   ret_cnt_q, ret_cnt_d;
  logic              issuing_q, issuing_d;  // read issue phase still running
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_d_q, last_d_d;    // 1: most recent grant went to D
  logic              pick_d;
  logic              filling;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      issuing_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      issuing_q   <= issuing_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_d_q    <= last_d_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    issuing_d   = issuing_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d_d    = last_d_q;
    // On a tie the side that did not win last time goes first.
    pick_d      = d_req && (!i_req || !last_d_q);
    unique case (state_q)
      StIdle: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        issuing_d   = 1'b0;
        if (i_req || d_req) begin
          last_d_d  = pick_d;
          issuing_d = 1'b1;
          if (pick_d) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            state_d = d_wr ? StWriteD : StFillD;
          end else begin
            addr_d  = i_addr;
            state_d = StFillI;
          end
        end
      end
      StFillI, StFillD: begin
        if (issuing_q) begin
          issue_cnt_d = issue_cnt_q + IdxW'(1);
          if (issue_cnt_q == LastIdx) issuing_d = 1'b0;
        end
        if (mem_rvalid) begin
          ret_cnt_d = ret_cnt_q + IdxW'(1);
          if (ret_cnt_q == LastIdx) state_d = StIdle;
        end
      end
      StWriteD: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    filling      = (state_q == StFillI) || (state_q == StFillD);
    busy         = (state_q != StIdle);
    i_gnt        = (state_q == StFillI);
    d_gnt        = (state_q == StFillD) || (state_q == StWriteD);
    // Returns outside a fill (stale after reset, or during a write) are dropped.
    i_data_valid = (state_q == StFillI) && mem_rvalid;
    d_data_valid = (state_q == StFillD) && mem_rvalid;
    i_word_idx   = i_data_valid ? ret_cnt_q : '0;
    d_word_idx   = d_data_valid ? ret_cnt_q : '0;
    i_done       = i_data_valid && (ret_cnt_q == LastIdx);
    d_done       = (d_data_valid && (ret_cnt_q == LastIdx)) || (state_q == StWriteD);
    fill_data    = mem_rdata;
    mem_en       = (filling && issuing_q) || (state_q == StWriteD);
    mem_wr       = (state_q == StWriteD);
    mem_addr     = '0;
    mem_wdata    = '0;
    if (filling && issuing_q) begin
      mem_addr = {addr_q[ADDR_W-1:Off], issue_cnt_q, 1'b0};
    end else if (state_q == StWriteD) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  // With a fixed-latency memory a fill lasts exactly WORDS_PER_BLOCK + MEM_LAT cycles.
  a_fill_len_i: assert property (@(posedge clk) disable iff (!rst)
    $rose(i_gnt) |-> ##(WORDS_PER_BLOCK + MEM_LAT - 1) i_done);
  a_fill_len_d: assert property (@(posedge clk) disable iff (!rst)
    ($rose(d_gnt) && !mem_wr) |-> ##(WORDS_PER_BLOCK + MEM_LAT - 1) d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_data_valid, i_done, d_gnt, d_data_valid, d_done;
  logic [2:0]    i_word_idx, d_word_idx;
  logic [DW-1:0] fill_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_wr, busy;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
    .i_word_idx(i_word_idx), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_data_valid(d_data_valid), .d_word_idx(d_word_idx), .d_done(d_done),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed, injective function of the byte address.
  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return a ^ 16'hA55A;
  endfunction

  // Memory model: read data appears LAT cycles after the accepted mem_en.
  logic [LAT-2:0] pv = '0;
  logic [DW-1:0]  pd [LAT-1];
  always @(posedge clk) begin
    mem_rvalid <= pv[LAT-2];
    mem_rdata  <= pd[LAT-2];
    pv <= {pv[LAT-3:0], mem_en && !mem_wr};
    for (int s = LAT - 2; s > 0; s--) pd[s] <= pd[s-1];
    pd[0] <= memfn(mem_addr);
  end

  // Scoreboard queues
  typedef struct {
    logic [2:0]    idx;
    logic [DW-1:0] data;
    logic          done;
  } word_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  word_t i_exp[$];
  word_t d_exp[$];
  wr_t   w_exp[$];
  int    pend_i = 0;
  int    pend_d = 0;

  task automatic push_fill(input bit side_d, input logic [AW-1:0] a);
    logic [AW-1:0] base;
    base = a & ~AW'(2 * WPB - 1);
    for (int k = 0; k < WPB; k++) begin
      word_t w;
      w.idx  = 3'(k);
      w.data = memfn(base + AW'(2 * k));
      w.done = (k == WPB - 1);
      if (side_d) d_exp.push_back(w);
      else i_exp.push_back(w);
    end
  endtask

  task automatic start_i(input logic [AW-1:0] a, input int n);
    i_req  = 1'b1;
    i_addr = a;
    pend_i = n;
    for (int j = 0; j < n; j++) push_fill(1'b0, a);
  endtask

  task automatic start_d(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    wr_t x;
    d_req   = 1'b1;
    d_wr    = wr;
    d_addr  = a;
    d_wdata = wd;
    pend_d  = 1;
    if (wr) begin
      x.addr = a;
      x.data = wd;
      w_exp.push_back(x);
    end else begin
      push_fill(1'b1, a);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    i_exp.delete();
    d_exp.delete();
    w_exp.delete();
    pend_i = 0;
    pend_d = 0;
    i_req  = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {i_gnt, i_data_valid, i_word_idx, i_done, d_gnt, d_data_valid, d_word_idx,
                 d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy}, '0);
  endtask

  // Behave like the cache controllers: drop req the cycle after the last done.
  task automatic run_until_idle(input int limit);
    int   n;
    logic di, dd;
    n = 0;
    while ((i_req || d_req || busy) && n < limit) begin
      @(negedge clk);
      di = i_done;
      dd = d_done;
      step();
      if (di && pend_i > 0) begin
        pend_i--;
        if (pend_i == 0) i_req = 1'b0;
      end
      if (dd && pend_d > 0) begin
        pend_d--;
        if (pend_d == 0) d_req = 1'b0;
      end
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL timeout: still busy after %0d cycles, expected idle", n);
      rst = 1'b0;
      flush();
      step();
      rst = 1'b1;
    end
  endtask

  // Monitor: arbitration model plus per-side and write scoreboards.
  bit    arb_pend = 1'b0;
  bit    last_d = 1'b0;
  bit    prev_done = 1'b0;
  logic  p_i, p_d, p_wr;
  bit    win_d;
  int    g_cyc = 0;
  bit    g_wr = 1'b0;
  word_t wm;
  wr_t   wx;

  always @(negedge clk) begin
    if (!rst) begin
      arb_pend  = 1'b0;
      last_d    = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("fill_data", fill_data, mem_rdata);
      check("both_gnt", i_gnt && d_gnt, 1'b0);
      check("i_valid_not_granted", i_data_valid && !i_gnt, 1'b0);
      check("d_valid_not_granted", d_data_valid && !d_gnt, 1'b0);
      check("mem_en_idle", mem_en && !busy, 1'b0);
      if (prev_done) check("idle_after_done", busy, 1'b0);
      if (arb_pend) begin
        if (p_i || p_d) begin
          win_d = p_d && (!p_i || !last_d);
          check("i_gnt", i_gnt, !win_d);
          check("d_gnt", d_gnt, win_d);
          if (win_d) check("grant_kind_wr", mem_wr, p_wr);
          last_d = win_d;
          g_cyc  = cyc;
          g_wr   = win_d && p_wr;
        end else begin
          check("idle_no_req", busy, 1'b0);
        end
      end
      arb_pend = !busy;
      p_i  = i_req;
      p_d  = d_req;
      p_wr = d_wr;

      if (i_data_valid) begin
        if (i_exp.size() == 0) begin
          check("i_unexpected_valid", i_data_valid, 1'b0);
        end else begin
          wm = i_exp.pop_front();
          check("i_word_idx", i_word_idx, wm.idx);
          check("i_data", fill_data, wm.data);
          check("i_done", i_done, wm.done);
        end
      end else begin
        check("i_done_alone", i_done, 1'b0);
      end

      if (d_data_valid) begin
        if (d_exp.size() == 0) begin
          check("d_unexpected_valid", d_data_valid, 1'b0);
        end else begin
          wm = d_exp.pop_front();
          check("d_word_idx", d_word_idx, wm.idx);
          check("d_data", fill_data, wm.data);
          check("d_done", d_done, wm.done);
        end
      end else begin
        check("d_done_alone", d_done, mem_en && mem_wr);
      end

      if (mem_en && mem_wr) begin
        check("write_d_gnt", d_gnt, 1'b1);
        check("write_no_valid", d_data_valid, 1'b0);
        if (w_exp.size() == 0) begin
          check("unexpected_write", mem_wr, 1'b0);
        end else begin
          wx = w_exp.pop_front();
          check("write_addr", mem_addr, wx.addr);
          check("write_data", mem_wdata, wx.data);
        end
      end

      if (i_done || d_done) check("duration", cyc - g_cyc, g_wr ? 0 : WPB + LAT - 1);
      prev_done = i_done || d_done;
    end
  end

  int            kind, k;
  logic [AW-1:0] ra, rb;
  logic [DW-1:0] rw;
  bit            rwr;

  initial begin
    #1;
    check_outs_zero("reset_outputs");
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single I fill from a misaligned address
    start_i(16'h1234, 1);
    run_until_idle(200);
    // Simultaneous requests: D first, then I; then again D
    start_i(16'h2000, 1);
    start_d(1'b0, 16'h3010, '0);
    run_until_idle(200);
    start_i(16'h2040, 1);
    start_d(1'b0, 16'h3050, '0);
    run_until_idle(200);
    // Single-word write
    start_d(1'b1, 16'h0100, 16'hBEEF);
    run_until_idle(200);
    // I req held across two fills
    start_i(16'h4444, 2);
    run_until_idle(200);
    // D req dropped mid-fill; inputs scrambled after grant
    start_d(1'b0, 16'h5670, '0);
    repeat (3) step();
    d_req   = 1'b0;
    pend_d  = 0;
    d_addr  = 16'hFFFF;
    d_wr    = 1'b1;
    run_until_idle(200);
    d_wr    = 1'b0;

    // Reset in the middle of an I fill
    start_i(16'h6780, 1);
    repeat (6) step();
    #2;
    rst = 1'b0;
    #1;
    check_outs_zero("abort_outputs");
    flush();
    repeat (2) step();
    rst = 1'b1;
    repeat (LAT + 4) step();
    start_i(16'h6780, 1);
    run_until_idle(200);

    // Randomised traffic
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      ra   = AW'($urandom);
      rb   = AW'($urandom) & 16'hFFFE;
      rw   = DW'($urandom);
      rwr  = 1'($urandom_range(0, 1));
      case (kind)
        0: start_i(ra, 1);
        1: start_d(rwr, rb, rw);
        2: begin
          start_i(ra, 1);
          start_d(rwr, rb, rw);
        end
        default: begin
          k = $urandom_range(1, 5);
          if (rwr) begin
            start_i(ra, 1);
            repeat (k) step();
            start_d(1'($urandom_range(0, 1)), rb, rw);
          end else begin
            start_d(1'b0, rb, rw);
            repeat (k) step();
            start_i(ra, 1);
          end
        end
      endcase
      run_until_idle(200);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (LAT + 2) step();
    check("i_queue_drained", i_exp.size(), 0);
    check("d_queue_drained", d_exp.size(), 0);
    check("w_queue_drained", w_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
